// File: rtl/keccak_xif_ctrl_if.sv
// ----------------------------------------------------------------------------
// keccak_xif_ctrl_if
//
// Purpose : Bundles the X-interface style offload signals between a RISC-V
//           core, the Keccak offload controller and the Keccak-f permutation
//           core into one interface.
//
// Modports:
//   master - environment side (core + permutation core): drives the issue,
//            commit and result-ready signals and the permutation done pulse.
//   slave  - keccak_xif_ctrl: drives issue ready/accept/writeback, the
//            permutation start pulse and the result transaction.
//
// Signals (direction as seen from the controller):
//   issue_valid_i / issue_ready_o       issue handshake
//   issue_instr_i [31:0]                offloaded instruction word
//   issue_id_i    [ID_WIDTH-1:0]        id of the offered instruction
//   issue_accept_o / issue_writeback_o  decode response
//   commit_valid_i / commit_id_i / commit_kill_i   commit or kill
//   perm_start_o / perm_done_i          permutation core pulses
//   result_valid_o / result_ready_i     result handshake
//   result_id_o / result_rd_o / result_data_o / result_we_o  result payload
// ----------------------------------------------------------------------------
interface keccak_xif_ctrl_if #(
  parameter int ID_WIDTH = 4
);

  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [31:0]         issue_instr_i;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic                issue_accept_o;
  logic                issue_writeback_o;

  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;

  logic                perm_start_o;
  logic                perm_done_i;

  logic                result_valid_o;
  logic                result_ready_i;
  logic [ID_WIDTH-1:0] result_id_o;
  logic [4:0]          result_rd_o;
  logic [31:0]         result_data_o;
  logic                result_we_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output perm_done_i, result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  perm_start_o,
    input  result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  perm_done_i, result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output perm_start_o,
    output result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o
  );

endinterface

// File: rtl/keccak_xif_ctrl.sv
// ----------------------------------------------------------------------------
// keccak_xif_ctrl
//
// Purpose : Offload controller for a single KECCAK_F instruction. Decodes the
//           offered instruction, waits for the core to commit it, launches
//           the Keccak-f permutation core with a one-cycle start pulse,
//           counts the permutation cycles and returns that count as the
//           instruction result.
//
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - asynchronous active-high reset, returns the controller to IDLE
//   xif    - keccak_xif_ctrl_if.slave (issue / commit / permutation / result)
//
// Parameters:
//   OPCODE      - major opcode of the Keccak instructions (custom-0)
//   FUNCT3_PERM - funct3 of the KECCAK_F permutation instruction
//   ID_WIDTH    - instruction id width (must match the interface)
//   CNT_WIDTH   - permutation cycle counter width (at most 32)
// ----------------------------------------------------------------------------
module keccak_xif_ctrl #(
  parameter logic [6:0] OPCODE      = 7'b0001011,
  parameter logic [2:0] FUNCT3_PERM = 3'b000,
  parameter int         ID_WIDTH    = 4,
  parameter int         CNT_WIDTH   = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  keccak_xif_ctrl_if.slave xif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_COMMIT,
    RUN,
    RESP
  } state_e;

  state_e              r_state;
  logic                r_issue_ready;
  logic                r_perm_start;
  logic                r_result_valid;
  logic                r_result_we;
  logic [ID_WIDTH-1:0] r_result_id;
  logic [4:0]          r_result_rd;
  logic [31:0]         r_result_data;

  // Instruction context captured at issue time.
  logic [ID_WIDTH-1:0] r_id;
  logic [4:0]          r_rd;
  logic                r_wb;

  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_accept;
  logic                 w_writeback;
  logic                 w_issue_hs;
  logic                 w_commit_hit;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  // Decode is purely combinational so the core gets its answer in the same
  // cycle it offers the instruction.
  assign w_accept    = (xif.issue_instr_i[6:0] == OPCODE) &&
                       (xif.issue_instr_i[14:12] == FUNCT3_PERM);
  assign w_writeback = w_accept && (xif.issue_instr_i[11:7] != 5'd0);
  assign w_issue_hs  = xif.issue_valid_i && r_issue_ready;

  assign w_commit_hit = xif.commit_valid_i && (xif.commit_id_i == r_id);

  // Saturating increment: the reported count sticks at all-ones rather than
  // wrapping to a misleadingly small number.
  assign w_cnt_inc = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // NOTE: every register here is assigned with <= so all of them update
  // together from the values present before the edge; the default arm and
  // the unconditional clear of r_perm_start keep each branch fully specified.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_issue_ready  <= 1'b1;
      r_perm_start   <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_we    <= 1'b0;
      r_result_id    <= '0;
      r_result_rd    <= '0;
      r_result_data  <= '0;
      r_id           <= '0;
      r_rd           <= '0;
      r_wb           <= 1'b0;
      r_cnt          <= '0;
    end else begin
      // Start is a single-cycle pulse; it is only raised on the commit edge.
      r_perm_start <= 1'b0;

      case (r_state)
        IDLE: begin
          // Non-Keccak instructions complete the handshake but are rejected
          // and leave the controller untouched.
          if (w_issue_hs && w_accept) begin
            r_id          <= xif.issue_id_i;
            r_rd          <= xif.issue_instr_i[11:7];
            r_wb          <= w_writeback;
            r_issue_ready <= 1'b0;
            r_state       <= WAIT_COMMIT;
          end
        end

        WAIT_COMMIT: begin
          // Commits for other in-flight ids belong to other units.
          if (w_commit_hit) begin
            if (xif.commit_kill_i) begin
              r_issue_ready <= 1'b1;
              r_state       <= IDLE;
            end else begin
              r_perm_start <= 1'b1;
              r_cnt        <= '0;
              r_state      <= RUN;
            end
          end
        end

        RUN: begin
          // The counter advances in every RUN cycle, start cycle included,
          // so the reported value is the number of RUN cycles up to and
          // including the one in which done arrived.
          r_cnt <= w_cnt_inc;
          if (xif.perm_done_i) begin
            r_result_data  <= 32'(w_cnt_inc);
            r_result_id    <= r_id;
            r_result_rd    <= r_rd;
            r_result_we    <= r_wb;
            r_result_valid <= 1'b1;
            r_state        <= RESP;
          end
        end

        RESP: begin
          // Payload registers are frozen here until the core takes them.
          if (xif.result_ready_i) begin
            r_result_valid <= 1'b0;
            r_issue_ready  <= 1'b1;
            r_state        <= IDLE;
          end
        end

        default: begin
          r_issue_ready <= 1'b1;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign xif.issue_ready_o     = r_issue_ready;
  assign xif.issue_accept_o    = w_accept;
  assign xif.issue_writeback_o = w_writeback;
  assign xif.perm_start_o      = r_perm_start;
  assign xif.result_valid_o    = r_result_valid;
  assign xif.result_id_o       = r_result_id;
  assign xif.result_rd_o       = r_result_rd;
  assign xif.result_data_o     = r_result_data;
  assign xif.result_we_o       = r_result_we;

endmodule

// File: tb/tb_keccak_xif_ctrl.sv
// ----------------------------------------------------------------------------
// tb_keccak_xif_ctrl
//
// Drives directed and random offload transactions into two controllers that
// share all inputs: one with the default 16-bit counter and one with a 4-bit
// counter so that counter saturation is reachable in a few cycles. Expected
// values come from a transaction-level model: decode from the instruction
// fields, the result count equals the number of RUN cycles up to the done
// cycle (clamped to the counter range), and one start pulse / one result per
// committed instruction, none for rejected or killed ones.
// ----------------------------------------------------------------------------
module tb_keccak_xif_ctrl;

  localparam logic [6:0] OPC = 7'b0001011;
  localparam logic [2:0] F3  = 3'b000;
  localparam int SMALL_MAX   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_start = 0;
  int n_resp  = 0;

  keccak_xif_ctrl_if #(.ID_WIDTH(4)) xif  ();
  keccak_xif_ctrl_if #(.ID_WIDTH(4)) xif2 ();

  keccak_xif_ctrl #(.ID_WIDTH(4), .CNT_WIDTH(16)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .xif   (xif)
  );

  keccak_xif_ctrl #(.ID_WIDTH(4), .CNT_WIDTH(4)) u_dut_small (
    .clk_i (clk),
    .rst_i (rst),
    .xif   (xif2)
  );

  assign xif2.issue_valid_i  = xif.issue_valid_i;
  assign xif2.issue_instr_i  = xif.issue_instr_i;
  assign xif2.issue_id_i     = xif.issue_id_i;
  assign xif2.commit_valid_i = xif.commit_valid_i;
  assign xif2.commit_id_i    = xif.commit_id_i;
  assign xif2.commit_kill_i  = xif.commit_kill_i;
  assign xif2.perm_done_i    = xif.perm_done_i;
  assign xif2.result_ready_i = xif.result_ready_i;

  always #5 clk = ~clk;

  // Event monitors: start pulses and completed result handshakes.
  always @(posedge clk) begin
    if (xif.perm_start_o) n_start++;
    if (xif.result_valid_o && xif.result_ready_i) n_resp++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete offload: issue, optional foreign commits, matching commit or
  // kill, permutation lasting run_len RUN cycles, result stalled for stall
  // cycles before the core accepts it.
  task automatic do_txn(input string tag, input logic [31:0] instr, input logic [3:0] id,
                        input int n_bad, input bit kill, input int run_len, input int stall);
    int  s0 = n_start;
    int  r0 = n_resp;
    bit  exp_acc;
    bit  exp_wb;
    int  exp_small;

    exp_acc   = (instr[6:0] == OPC) && (instr[14:12] == F3);
    exp_wb    = exp_acc && (instr[11:7] != 5'd0);
    exp_small = (run_len > SMALL_MAX) ? SMALL_MAX : run_len;

    @(negedge clk);
    check({tag, ".ready_idle"}, 32'(xif.issue_ready_o), 32'd1);
    xif.issue_valid_i = 1'b1;
    xif.issue_instr_i = instr;
    xif.issue_id_i    = id;
    #1;
    check({tag, ".accept"},    32'(xif.issue_accept_o),    32'(exp_acc));
    check({tag, ".writeback"}, 32'(xif.issue_writeback_o), 32'(exp_wb));

    @(negedge clk);
    xif.issue_valid_i = 1'b0;
    xif.issue_instr_i = $urandom;

    if (!exp_acc) begin
      check({tag, ".rej_ready"}, 32'(xif.issue_ready_o),  32'd1);
      check({tag, ".rej_valid"}, 32'(xif.result_valid_o), 32'd0);
      check({tag, ".rej_start"}, 32'(n_start - s0),       32'd0);
      return;
    end
    check({tag, ".busy"}, 32'(xif.issue_ready_o), 32'd0);

    // Commits for other ids (and stray done pulses) must be ignored.
    for (int i = 0; i < n_bad; i++) begin
      xif.commit_valid_i = 1'b1;
      xif.commit_id_i    = id ^ 4'(5 + i);
      xif.commit_kill_i  = 1'($urandom);
      xif.perm_done_i    = 1'($urandom);
      @(negedge clk);
      check({tag, ".foreign_start"}, 32'(xif.perm_start_o), 32'd0);
    end
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
    xif.perm_done_i    = 1'b0;
    @(negedge clk);
    xif.commit_valid_i = 1'b0;
    xif.commit_kill_i  = 1'b0;

    if (kill) begin
      check({tag, ".kill_start"}, 32'(xif.perm_start_o),   32'd0);
      check({tag, ".kill_ready"}, 32'(xif.issue_ready_o),  32'd1);
      check({tag, ".kill_valid"}, 32'(xif.result_valid_o), 32'd0);
      check({tag, ".kill_nstart"}, 32'(n_start - s0),      32'd0);
      return;
    end

    // One cycle after the commit: start pulse, first RUN cycle.
    check({tag, ".start"}, 32'(xif.perm_start_o), 32'd1);
    for (int c = 1; c <= run_len; c++) begin
      if (c == 2) check({tag, ".start_once"}, 32'(xif.perm_start_o), 32'd0);
      xif.perm_done_i = (c == run_len);
      @(negedge clk);
    end
    xif.perm_done_i = 1'b0;

    // One cycle after done: result presented and held through the stall.
    for (int s = 0; s <= stall; s++) begin
      check({tag, ".res_valid"}, 32'(xif.result_valid_o), 32'd1);
      check({tag, ".res_id"},    32'(xif.result_id_o),    32'(id));
      check({tag, ".res_rd"},    32'(xif.result_rd_o),    32'(instr[11:7]));
      check({tag, ".res_we"},    32'(xif.result_we_o),    32'(exp_wb));
      check({tag, ".res_data"},  xif.result_data_o,       32'(run_len));
      check({tag, ".res_data_sat"}, xif2.result_data_o,   32'(exp_small));
      xif.result_ready_i = (s == stall);
      @(negedge clk);
    end
    xif.result_ready_i = 1'b0;

    check({tag, ".post_valid"}, 32'(xif.result_valid_o), 32'd0);
    check({tag, ".post_ready"}, 32'(xif.issue_ready_o),  32'd1);
    check({tag, ".nstart"},     32'(n_start - s0),       32'd1);
    check({tag, ".nresp"},      32'(n_resp - r0),        32'd1);
  endtask

  // Launch a permutation, then assert reset mid-RUN or mid-RESP and confirm
  // that a late done pulse does not produce a result.
  task automatic reset_abort(input string tag, input bit in_resp);
    @(negedge clk);
    xif.issue_valid_i = 1'b1;
    xif.issue_instr_i = 32'h0000_050B;
    xif.issue_id_i    = 4'd1;
    @(negedge clk);
    xif.issue_valid_i  = 1'b0;
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = 4'd1;
    @(negedge clk);
    xif.commit_valid_i = 1'b0;
    if (in_resp) begin
      xif.perm_done_i = 1'b1;
      @(negedge clk);
      xif.perm_done_i = 1'b0;
      check({tag, ".pre_valid"}, 32'(xif.result_valid_o), 32'd1);
    end else begin
      repeat (3) @(negedge clk);
    end

    #2 rst = 1'b1;
    #1;
    check({tag, ".rst_start"}, 32'(xif.perm_start_o),   32'd0);
    check({tag, ".rst_valid"}, 32'(xif.result_valid_o), 32'd0);
    check({tag, ".rst_we"},    32'(xif.result_we_o),    32'd0);
    check({tag, ".rst_data"},  xif.result_data_o,       32'd0);
    check({tag, ".rst_id"},    32'(xif.result_id_o),    32'd0);
    check({tag, ".rst_rd"},    32'(xif.result_rd_o),    32'd0);

    @(negedge clk);
    rst = 1'b0;
    check({tag, ".rel_ready"}, 32'(xif.issue_ready_o), 32'd1);
    xif.perm_done_i = 1'b1;
    @(negedge clk);
    xif.perm_done_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check({tag, ".late_valid"}, 32'(xif.result_valid_o), 32'd0);
      check({tag, ".late_start"}, 32'(xif.perm_start_o),   32'd0);
    end
  endtask

  initial begin
    logic [31:0] instr;

    xif.issue_valid_i  = 1'b0;
    xif.issue_instr_i  = '0;
    xif.issue_id_i     = '0;
    xif.commit_valid_i = 1'b0;
    xif.commit_id_i    = '0;
    xif.commit_kill_i  = 1'b0;
    xif.perm_done_i    = 1'b0;
    xif.result_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.valid", 32'(xif.result_valid_o), 32'd0);
    check("reset.start", 32'(xif.perm_start_o),   32'd0);
    check("reset.data",  xif.result_data_o,       32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset.ready", 32'(xif.issue_ready_o), 32'd1);

    // rd=10; done in the 10th RUN cycle (start cycle counts as the first).
    do_txn("basic",   32'h0000_050B, 4'd3, 0, 1'b0, 10, 0);
    do_txn("non_kcc", 32'h0000_0033, 4'd4, 0, 1'b0, 1, 0);
    do_txn("kill",    32'h0000_050B, 4'd5, 0, 1'b1, 1, 0);
    do_txn("foreign", 32'h0000_050B, 4'd2, 1, 1'b0, 4, 0);
    do_txn("stall",   32'h0000_0D8B, 4'd6, 0, 1'b0, 7, 5);
    do_txn("rd0",     32'h0000_000B, 4'd8, 0, 1'b0, 1, 1);
    do_txn("sat",     32'h0000_0F8B, 4'd9, 0, 1'b0, 20, 0);
    do_txn("f3_bad",  32'h0000_150B, 4'd1, 0, 1'b0, 1, 0);

    reset_abort("rst_run",  1'b0);
    reset_abort("rst_resp", 1'b1);

    for (int t = 0; t < 40; t++) begin
      instr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        instr[6:0]   = OPC;
        instr[14:12] = F3;
      end
      if ($urandom_range(0, 5) == 0) instr[11:7] = 5'd0;
      do_txn("rand", instr, 4'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), $urandom_range(1, 24), $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keccak_xif_ctrl.md
KECCAK_XIF_CTRL -- requirements
Module: keccak_xif_ctrl

Interface
REQ-001 Parameter OPCODE, default 7'b0001011, custom-0 major opcode decoded as Keccak instruction.
REQ-002 Parameter FUNCT3_PERM, default 3'b000, funct3 selecting the KECCAK_F permutation instruction.
REQ-003 Parameter ID_WIDTH, default 4, width of the XIF instruction id.
REQ-004 Parameter CNT_WIDTH, default 16, width of the permutation cycle counter.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 issue_valid_i  in  1  core presents an instruction offload.
REQ-008 issue_ready_o  out  1  controller can take an issue transaction.
REQ-009 issue_instr_i  in  32  offloaded instruction word.
REQ-010 issue_id_i  in  ID_WIDTH  id of the offered instruction.
REQ-011 issue_accept_o  out  1  instruction is a Keccak instruction and is taken.
REQ-012 issue_writeback_o  out  1  accepted instruction writes a GPR.
REQ-013 commit_valid_i  in  1  commit transaction valid.
REQ-014 commit_id_i  in  ID_WIDTH  id being committed or killed.
REQ-015 commit_kill_i  in  1  1 = kill, 0 = commit.
REQ-016 perm_start_o  out  1  one-cycle start pulse to the Keccak-f permutation core.
REQ-017 perm_done_i  in  1  one-cycle completion pulse from the permutation core.
REQ-018 result_valid_o  out  1  result transaction valid.
REQ-019 result_ready_i  in  1  core accepts the result.
REQ-020 result_id_o  out  ID_WIDTH  id of the completed instruction.
REQ-021 result_rd_o  out  5  destination register, instr[11:7].
REQ-022 result_data_o  out  32  zero-extended cycle count of the permutation.
REQ-023 result_we_o  out  1  register write enable for the result.

Function
REQ-024 FSM states IDLE, WAIT_COMMIT, RUN, RESP; reset state IDLE.
REQ-025 issue_ready_o is 1 only in IDLE; issue handshake = issue_valid_i & issue_ready_o.
REQ-026 issue_accept_o is combinational: 1 iff instr[6:0]==OPCODE and instr[14:12]==FUNCT3_PERM; issue_writeback_o = issue_accept_o & (instr[11:7]!=0).
REQ-027 Handshake with accept=0: no state change, no result, remain IDLE.
REQ-028 Handshake with accept=1: latch id, rd, writeback flag; go to WAIT_COMMIT next cycle.
REQ-029 WAIT_COMMIT: commit_valid_i with commit_id_i==latched id and kill=0 -> assert perm_start_o for exactly one cycle (the following cycle), clear counter, go RUN.
REQ-030 WAIT_COMMIT: matching id with kill=1 -> IDLE, no perm_start_o, no result; non-matching ids ignored.
REQ-031 RUN: counter increments by 1 each cycle, including the start cycle; saturates at all-ones, never wraps.
REQ-032 RUN: perm_done_i -> latch counter value (including that cycle's increment) into result_data_o, go RESP; perm_done_i outside RUN ignored.
REQ-033 RESP: result_valid_o=1; result_id_o/rd/data/we stable until result_valid_o & result_ready_i; then IDLE next cycle.
REQ-034 result_we_o equals the latched writeback flag.
REQ-035 Back-to-back: issue_ready_o returns to 1 the cycle after the result handshake.
REQ-036 Latency from commit to perm_start_o: 1 cycle; from perm_done_i to result_valid_o: 1 cycle.

Reset
REQ-037 rst_i asserted at any time, including mid-RUN or mid-RESP: state IDLE immediately; perm_start_o, result_valid_o, result_we_o, result_data_o, result_id_o, result_rd_o, counter all 0; issue_ready_o 1 after release.
REQ-038 perm_done_i pulse arriving after a reset that aborted RUN is ignored.

Verification
REQ-039 Issue 0x0000050B id 3, commit id 3 kill 0, done 10 cycles after start -> accept=1, writeback=1, one start pulse, result id 3, rd 10, data 10, we 1.
REQ-040 Issue 0x00000033 (non-Keccak) -> accept=0, stays IDLE, no start, no result.
REQ-041 Accept id 5, commit id 5 kill 1 -> no perm_start_o, no result, issue_ready_o 1 next cycle.
REQ-042 Accept id 2, commit id 7 then id 2 -> start only after id 2 commit.
REQ-043 result_ready_i held 0 for 5 cycles in RESP -> result outputs stable, then handshake, IDLE.
REQ-044 rst_i pulsed mid-RUN, later perm_done_i -> all outputs 0, no result_valid_o.
